// File: rtl/constants_pkg.sv
// Shared widths, state and requester-id types for the main-memory arbiter.
package constants_pkg;

  localparam int ADDR_W = 32;
  localparam int ICLLEN = 128;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return (id == REQ_DC) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2
  import constants_pkg::*;
(
  input  logic    ic_req,
  input  logic    dc_req,
  input  req_id_t last,
  output req_id_t winner,
  output logic    valid
);

  // Winner selection from the request pair and the last-served id
  always_comb begin
    winner = REQ_IC;
    valid  = 1'b0;
    case ({dc_req, ic_req})
      2'b01: begin
        winner = REQ_IC;
        valid  = 1'b1;
      end
      2'b10: begin
        winner = REQ_DC;
        valid  = 1'b1;
      end
      2'b11: begin
        winner = (last == REQ_IC) ? REQ_DC : REQ_IC;
        valid  = 1'b1;
      end
      default: begin
        winner = REQ_IC;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the line-wide main memory port between icache refill and dcache refill/write-back.
module mem_arbiter
  import constants_pkg::*;
#(
  parameter int ADDR_W  = constants_pkg::ADDR_W,
  parameter int LINE_W  = ICLLEN,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rdy,
  output logic [LINE_W-1:0] ic_data,
  output logic              ic_err,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_rdy,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT - 1 : 0);

  arb_state_t        state_r;
  arb_state_t        state_s;
  req_id_t           owner_r;
  req_id_t           last_r;
  req_id_t           pick_id_s;
  logic              pick_vld_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              done_s;
  logic              abort_s;
  logic [LINE_W-1:0] rsp_data_s;

  rr_pick2 u_pick (
    .ic_req (ic_req),
    .dc_req (dc_req),
    .last   (last_r),
    .winner (pick_id_s),
    .valid  (pick_vld_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and completion/abort decode
  always_comb begin
    state_s    = state_r;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    rsp_data_s = {LINE_W{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        if (pick_vld_s) begin
          state_s = ARB_WAIT;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (mem_rdy) begin
          done_s     = 1'b1;
          rsp_data_s = mem_rdata;
          state_s    = ARB_RESP;
        end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
          abort_s = 1'b1;
          state_s = ARB_RESP;
        end else begin
          state_s = ARB_WAIT;
        end
      end
      ARB_RESP: state_s = ARB_IDLE;
      default:  state_s = ARB_IDLE;
    endcase
  end

  // Request latch, memory drive, response registers and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r   <= REQ_IC;
      last_r    <= REQ_DC;
      cnt_r     <= {CNT_W{1'b0}};
      grant     <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {LINE_W{1'b0}};
      ic_rdy    <= 1'b0;
      ic_err    <= 1'b0;
      ic_data   <= {LINE_W{1'b0}};
      dc_rdy    <= 1'b0;
      dc_err    <= 1'b0;
      dc_rdata  <= {LINE_W{1'b0}};
    end else begin
      // rdy/err are single-cycle pulses; data registers hold
      ic_rdy <= 1'b0;
      ic_err <= 1'b0;
      dc_rdy <= 1'b0;
      dc_err <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_vld_s) begin
            owner_r <= pick_id_s;
            grant   <= id_onehot(pick_id_s);
            mem_req <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            if (pick_id_s == REQ_DC) begin
              mem_we    <= dc_we;
              mem_addr  <= dc_addr;
              mem_wdata <= dc_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= ic_addr;
              mem_wdata <= {LINE_W{1'b0}};
            end
          end
        end
        ARB_WAIT: begin
          if (done_s || abort_s) begin
            mem_req <= 1'b0;
            if (owner_r == REQ_DC) begin
              dc_rdy   <= 1'b1;
              dc_err   <= abort_s;
              dc_rdata <= rsp_data_s;
            end else begin
              ic_rdy  <= 1'b1;
              ic_err  <= abort_s;
              ic_data <= rsp_data_s;
            end
            if (done_s) begin
              last_r <= owner_r;
            end
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ARB_RESP: begin
          grant <= 2'b00;
        end
        default: begin
          grant   <= 2'b00;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected responses, a monitor pops and checks them.
module tb_mem_arbiter;

  typedef struct {
    logic         is_dc;
    logic         err;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    int           lat;
    int           mf;
    int           mc;
    logic [31:0]  a;
    logic         we;
    logic [127:0] wd;
    logic [1:0]   g;
  } obs_t;

  logic         clk;
  logic         rst;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_rdy;
  logic [127:0] ic_data;
  logic         ic_err;
  logic         dc_req;
  logic         dc_we;
  logic [31:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_rdy;
  logic [127:0] dc_rdata;
  logic         dc_err;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_rdy;
  logic [127:0] mem_rdata;
  logic [1:0]   grant;

  logic mem_on;
  logic force_rdy;
  int   n_checks;
  int   n_fail;
  int   n_ic;
  int   n_dc;
  exp_t exp_q[$];
  exp_t mon_e;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdy(ic_rdy), .ic_data(ic_data), .ic_err(ic_err),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdy(dc_rdy), .dc_rdata(dc_rdata), .dc_err(dc_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (a == 32'h0000_0100) return 128'h00408093_00308093_00208093_00108093;
    return {a ^ 32'h5A5A_0000, ~a, a + 32'h1, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic is_dc, input logic err, input logic [127:0] data);
    exp_t e;
    e.is_dc = is_dc;
    e.err   = err;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Single-cycle memory: answers one cycle after it sees mem_req
  always @(posedge clk) begin
    if (force_rdy) begin
      mem_rdy   <= 1'b1;
      mem_rdata <= 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    end else if (mem_on && mem_req && !mem_rdy) begin
      mem_rdy   <= 1'b1;
      mem_rdata <= mem_line(mem_addr);
    end else begin
      mem_rdy <= 1'b0;
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (ic_rdy || dc_rdy) begin
      chk("rdy_exclusive", {127'd0, ic_rdy & dc_rdy}, 128'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {126'd0, ic_rdy, dc_rdy}, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", {127'd0, dc_rdy}, {127'd0, mon_e.is_dc});
        chk("rsp_err", {127'd0, dc_rdy ? dc_err : ic_err}, {127'd0, mon_e.err});
        chk("rsp_data", dc_rdy ? dc_rdata : ic_data, mon_e.data);
        chk("rsp_grant", {126'd0, grant}, mon_e.is_dc ? 128'd2 : 128'd1);
        if (dc_rdy) n_dc++;
        else n_ic++;
      end
    end
  end

  task automatic txn(input logic is_dc, input logic we, input logic [31:0] addr,
                     input logic [127:0] wd, output obs_t o);
    bit got;
    got  = 1'b0;
    o.lat = 0; o.mf = -1; o.mc = 0; o.a = 32'h0; o.we = 1'b0; o.wd = 128'h0; o.g = 2'b00;
    @(posedge clk); #1;
    if (is_dc) begin
      dc_we = we; dc_addr = addr; dc_wdata = wd; dc_req = 1'b1;
    end else begin
      ic_addr = addr; ic_req = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (o.mf < 0) begin
          o.mf = c; o.a = mem_addr; o.we = mem_we; o.wd = mem_wdata; o.g = grant;
        end
        o.mc++;
      end
      if ((is_dc && dc_rdy) || (!is_dc && ic_rdy)) begin
        o.lat = c;
        got   = 1'b1;
        break;
      end
    end
    if (!got) chk("rdy_wait_bound", 128'd0, 128'd1);
    @(posedge clk); #1;
    if (is_dc) dc_req = 1'b0;
    else ic_req = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, {126'd0, grant}, 128'd0);
    chk({tag, "_ctl"}, {123'd0, mem_req, mem_we, ic_rdy, dc_rdy, ic_err | dc_err}, 128'd0);
    chk({tag, "_addr"}, {96'd0, mem_addr}, 128'd0);
    chk({tag, "_wdata"}, mem_wdata, 128'd0);
    chk({tag, "_ic_data"}, ic_data, 128'd0);
    chk({tag, "_dc_rdata"}, dc_rdata, 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    obs_t oa;
    obs_t ob;
    int   n;
    int   ic0;
    int   dc0;
    n_checks = 0; n_fail = 0; n_ic = 0; n_dc = 0;
    rst = 1'b0; ic_req = 1'b0; ic_addr = 32'h0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = 32'h0; dc_wdata = 128'h0; mem_on = 1'b1; force_rdy = 1'b0;
    mem_rdy = 1'b0; mem_rdata = 128'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Reset then IC read
    exp_push(1'b0, 1'b0, 128'h00408093_00308093_00208093_00108093);
    txn(1'b0, 1'b0, 32'h0000_0100, 128'h0, oa);
    chk("t1_lat", 128'(oa.lat), 128'd3);
    chk("t1_mreq_cycle", 128'(oa.mf), 128'd1);
    chk("t1_addr", {96'd0, oa.a}, 128'h100);
    chk("t1_we", {127'd0, oa.we}, 128'd0);
    chk("t1_grant", {126'd0, oa.g}, 128'd1);

    // Simultaneous requests after reset: IC first, then DC
    do_reset();
    exp_push(1'b0, 1'b0, mem_line(32'h0000_0110));
    exp_push(1'b1, 1'b0, mem_line(32'h0000_0210));
    fork
      txn(1'b0, 1'b0, 32'h0000_0110, 128'h0, oa);
      txn(1'b1, 1'b0, 32'h0000_0210, 128'h0, ob);
    join
    chk("t2_ic_lat", 128'(oa.lat), 128'd3);
    chk("t2_dc_lat", 128'(ob.lat), 128'd7);

    // Write-back
    exp_push(1'b1, 1'b0, mem_line(32'h0000_0200));
    txn(1'b1, 1'b1, 32'h0000_0200, {4{32'hDEAD_BEEF}}, oa);
    chk("t3_lat", 128'(oa.lat), 128'd3);
    chk("t3_we", {127'd0, oa.we}, 128'd1);
    chk("t3_addr", {96'd0, oa.a}, 128'h200);
    chk("t3_wdata", oa.wd, {4{32'hDEAD_BEEF}});
    chk("t3_grant", {126'd0, oa.g}, 128'd2);
    chk("t3_ic_quiet", {126'd0, ic_rdy, ic_err}, 128'd0);

    // Timeout: memory silent, abort after 4 WAIT cycles, late mem_rdy ignored
    mem_on = 1'b0;
    exp_push(1'b1, 1'b1, 128'h0);
    txn(1'b1, 1'b0, 32'h0000_0300, 128'h0, oa);
    chk("t4_lat", 128'(oa.lat), 128'd5);
    chk("t4_mreq_cycles", 128'(oa.mc), 128'd4);
    mem_on = 1'b1;
    @(posedge clk); #1 force_rdy = 1'b1;
    @(posedge clk); #1 force_rdy = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ic_rdy || dc_rdy || mem_req) n++;
    end
    chk("t4_late_rdy_ignored", 128'(n), 128'd0);

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    ic_addr = 32'h0000_0400; ic_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_wait", {127'd0, mem_req}, 128'd1);
    #2 rst = 1'b0;
    #1 chk_zero("t5_midreset");
    ic_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    exp_push(1'b0, 1'b0, mem_line(32'h0000_0500));
    txn(1'b0, 1'b0, 32'h0000_0500, 128'h0, oa);
    chk("t5_lat_after", 128'(oa.lat), 128'd3);

    // Tie right after IC was served: DC wins
    exp_push(1'b1, 1'b0, mem_line(32'h0000_0610));
    exp_push(1'b0, 1'b0, mem_line(32'h0000_0600));
    fork
      txn(1'b0, 1'b0, 32'h0000_0600, 128'h0, oa);
      txn(1'b1, 1'b0, 32'h0000_0610, 128'h0, ob);
    join
    chk("t5b_dc_lat", 128'(ob.lat), 128'd3);
    chk("t5b_ic_lat", 128'(oa.lat), 128'd7);

    // Fairness under load: 10 transactions, strictly alternating
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_push(1'b0, 1'b0, mem_line(32'h0000_1000 + 32'(k) * 32'h10));
      exp_push(1'b1, 1'b0, mem_line(32'h0000_2000 + 32'(k) * 32'h10));
    end
    ic0 = n_ic;
    dc0 = n_dc;
    fork
      begin
        obs_t oi;
        for (int k = 0; k < 5; k++) txn(1'b0, 1'b0, 32'h0000_1000 + 32'(k) * 32'h10, 128'h0, oi);
      end
      begin
        obs_t od;
        for (int k = 0; k < 5; k++) txn(1'b1, 1'b0, 32'h0000_2000 + 32'(k) * 32'h10, 128'h0, od);
      end
    join
    repeat (4) @(negedge clk);
    chk("t6_ic_count", 128'(n_ic - ic0), 128'd5);
    chk("t6_dc_count", 128'(n_dc - dc0), 128'd5);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
